// File: rtl/fetch_buffer_if.sv
// Fetch-stage bus bundle: PC register link, instruction-memory handshake,
// redirect input and the decode-side valid/ready queue head.
interface fetch_buffer_if #(
    parameter int AW = 32
);
    logic [AW-1:0] pc_i;
    logic          pc_adv_o;
    logic          imem_req_o;
    logic [AW-1:0] imem_addr_o;
    logic          imem_gnt_i;
    logic          imem_rvalid_i;
    logic [31:0]   imem_rdata_i;
    logic          flush_i;
    logic          id_valid_o;
    logic [31:0]   id_instr_o;
    logic [AW-1:0] id_pc_o;
    logic          id_ready_i;

    // Fetch stage side.
    modport master (
        input  pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, flush_i, id_ready_i,
        output pc_adv_o, imem_req_o, imem_addr_o, id_valid_o, id_instr_o, id_pc_o
    );

    // Environment side (PC register, instruction memory, decode).
    modport slave (
        output pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, flush_i, id_ready_i,
        input  pc_adv_o, imem_req_o, imem_addr_o, id_valid_o, id_instr_o, id_pc_o
    );
endinterface

// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: issues pc_i to instruction memory, advances the PC
// register on each grant, queues returned instructions in order for decode and
// discards stale responses after a redirect.
module fetch_buffer #(
    parameter int DEPTH = 2,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    fetch_buffer_if.master bus
);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    // alloc: next slot to grant, fill: next slot to receive data, rd: queue head.
    logic [PW-1:0] alloc_reg;
    logic [PW-1:0] fill_reg;
    logic [PW-1:0] rd_reg;
    // Responses still owed by memory that belong to a flushed path.
    logic [PW-1:0] discard_reg;
    // Keeps the request off for one cycle after reset while memory settles.
    logic          rst_hold_reg;

    logic [AW-1:0] slot_pc    [DEPTH];
    logic [31:0]   slot_instr [DEPTH];

    logic [PW-1:0] used;
    logic [PW-1:0] pending;
    logic [PW:0]   occupancy;
    logic          req;
    logic          grant;
    logic          pop;
    logic          rsp_drop;
    logic          rsp_live;

    assign used      = alloc_reg - rd_reg;
    assign pending   = alloc_reg - fill_reg;
    assign occupancy = {1'b0, used} + {1'b0, discard_reg};

    assign req   = !rst && !rst_hold_reg && !bus.flush_i && (occupancy < (PW+1)'(DEPTH));
    assign grant = req && bus.imem_gnt_i;

    // Stale responses are always older than live ones, so they are dropped first.
    assign rsp_drop = bus.imem_rvalid_i && (discard_reg != '0);
    assign rsp_live = bus.imem_rvalid_i && (discard_reg == '0) && (pending != '0);

    assign bus.imem_req_o  = req;
    assign bus.imem_addr_o = bus.pc_i;
    assign bus.pc_adv_o    = grant;

    assign bus.id_valid_o = (fill_reg != rd_reg);
    assign bus.id_pc_o    = slot_pc[rd_reg[IW-1:0]];
    assign bus.id_instr_o = slot_instr[rd_reg[IW-1:0]];

    // A redirect ignores the decode handshake in the same cycle.
    assign pop = bus.id_valid_o && bus.id_ready_i && !bus.flush_i;

    // Pointer and discard bookkeeping; a flush collapses the queue onto alloc.
    always_ff @(posedge clk) begin
        if (rst) begin
            alloc_reg    <= '0;
            fill_reg     <= '0;
            rd_reg       <= '0;
            discard_reg  <= '0;
            rst_hold_reg <= 1'b1;
        end else begin
            rst_hold_reg <= 1'b0;
            if (bus.flush_i) begin
                fill_reg    <= alloc_reg;
                rd_reg      <= alloc_reg;
                // Everything still owed becomes stale, minus a response arriving now.
                discard_reg <= discard_reg + pending - ((rsp_drop || rsp_live) ? PTR_ONE : '0);
            end else begin
                if (grant) begin
                    alloc_reg <= alloc_reg + PTR_ONE;
                end
                if (rsp_live) begin
                    fill_reg <= fill_reg + PTR_ONE;
                end
                if (rsp_drop) begin
                    discard_reg <= discard_reg - PTR_ONE;
                end
                if (pop) begin
                    rd_reg <= rd_reg + PTR_ONE;
                end
            end
        end
    end

    // Slot storage: PC captured at grant, instruction captured at response.
    always_ff @(posedge clk) begin
        if (grant) begin
            slot_pc[alloc_reg[IW-1:0]] <= bus.pc_i;
        end
        if (rsp_live && !bus.flush_i && !rst) begin
            slot_instr[fill_reg[IW-1:0]] <= bus.imem_rdata_i;
        end
    end

    // A response with nothing outstanding means the memory broke the protocol.
    assert property (@(posedge clk) disable iff (rst)
        !(bus.imem_rvalid_i && (discard_reg == '0) && (pending == '0)));

endmodule
